riscv_str_unleet: RTL and testbench

Multi-cycle leet-decode unit for the EX stage, alongside the string-ops unit. It accepts a packed 4-character word and restores letters from their leet digits ('3'→e, '5'→s, '1'→l), emitting lower- or upper-case letters as selected by the operator. It processes one byte per cycle through a small FSM and handshakes with the pipeline via `ready_o` / `ex_ready_i`, mirroring the encoding side.

---
 rtl/riscv_str_unleet.sv | 143 ++++++++++++++
 tb/tb_riscv_str_unleet.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_str_unleet.sv
// Multi-cycle leet-decode unit for the EX stage: restores '3','5','1' to e/s/l, one byte per cycle.
// Define STR_UNLEET_EXT_EN to also map '0','4','7' to o/a/t.

package riscv_defines;
    localparam int STR_OP_WIDTH = 3;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET      = 3'b000;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UNLEET    = 3'b001;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UNLEET_UP = 3'b010;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_REV       = 3'b011;
endpackage

module riscv_str_unleet_byte (
    input  logic [7:0] byte_i,
    input  logic       up_i,
    output logic [7:0] byte_o,
    output logic       hit_o
);
    logic [7:0] lower;

    always_comb begin
        lower = byte_i;
        hit_o = 1'b1;
        case (byte_i)
            8'h33:   lower = 8'h65;
            8'h35:   lower = 8'h73;
            8'h31:   lower = 8'h6C;
`ifdef STR_UNLEET_EXT_EN
            8'h30:   lower = 8'h6F;
            8'h34:   lower = 8'h61;
            8'h37:   lower = 8'h74;
`endif
            default: hit_o = 1'b0;
        endcase
        // Upper case differs from lower case only in bit 5.
        byte_o = (hit_o && up_i) ? (lower & 8'hDF) : lower;
    end
endmodule

module riscv_str_unleet
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    input  logic                    ex_ready_i,
    output logic [31:0]             result_o,
    output logic [2:0]              subst_cnt_o,
    output logic                    ready_o
);
    typedef enum logic [1:0] {S_IDLE, S_BYTE, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] work_q, work_d;
    logic        up_q, up_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  subst_cnt_q, subst_cnt_d;

    logic [7:0]  cur_byte;
    logic [7:0]  dec_byte;
    logic        dec_hit;
    logic        is_unleet;

    assign cur_byte  = work_q[{idx_q, 3'b000} +: 8];
    assign is_unleet = (operator_i == STR_OP_UNLEET) || (operator_i == STR_OP_UNLEET_UP);

    riscv_str_unleet_byte u_dec (
        .byte_i (cur_byte),
        .up_i   (up_q),
        .byte_o (dec_byte),
        .hit_o  (dec_hit)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        work_d      = work_q;
        up_d        = up_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        subst_cnt_d = subst_cnt_q;
        ready_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (enable_i && is_unleet) begin
                    ready_o = 1'b0;
                    work_d  = operand_i;
                    up_d    = (operator_i == STR_OP_UNLEET_UP);
                    idx_d   = 2'd0;
                    cnt_d   = 3'd0;
                    state_d = S_BYTE;
                end
            end
            S_BYTE: begin
                if (!enable_i) begin
                    // Abandoned instruction: the partial work never reaches the outputs.
                    state_d = S_IDLE;
                end else begin
                    work_d[{idx_q, 3'b000} +: 8] = dec_byte;
                    if (dec_hit) cnt_d = cnt_q + 3'd1;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d     = S_DONE;
                        result_d    = work_d;
                        subst_cnt_d = cnt_d;
                    end
                end
            end
            S_DONE: begin
                ready_o = 1'b1;
                if (ex_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            work_q      <= 32'd0;
            up_q        <= 1'b0;
            cnt_q       <= 3'd0;
            result_q    <= 32'd0;
            subst_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            work_q      <= work_d;
            up_q        <= up_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            subst_cnt_q <= subst_cnt_d;
        end
    end

    assign result_o    = result_q;
    assign subst_cnt_o = subst_cnt_q;
endmodule

// File: tb/tb_riscv_str_unleet.sv
// Directed bench for riscv_str_unleet: vector table plus stall, abort and reset sequences.
module tb_riscv_str_unleet;
    import riscv_defines::*;

    logic                    clk;
    logic                    rst_n;
    logic                    enable_i;
    logic [STR_OP_WIDTH-1:0] operator_i;
    logic [31:0]             operand_i;
    logic                    ex_ready_i;
    logic [31:0]             result_o;
    logic [2:0]              subst_cnt_o;
    logic                    ready_o;

    int total = 0;
    int bad   = 0;

    riscv_str_unleet dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable_i),
        .operator_i  (operator_i),
        .operand_i   (operand_i),
        .ex_ready_i  (ex_ready_i),
        .result_o    (result_o),
        .subst_cnt_o (subst_cnt_o),
        .ready_o     (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        logic [STR_OP_WIDTH-1:0] op;
        logic [31:0]             opd;
        logic [31:0]             res;
        logic [2:0]              cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Full operation with ex_ready held high; leaves the unit idle with enable low.
    task automatic run_op(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] opd,
                          input logic [31:0] er, input logic [2:0] ec, input string nm);
        enable_i   = 1'b1;
        operator_i = op;
        operand_i  = opd;
        ex_ready_i = 1'b1;
        #1;
        chk({nm, " accept ready"}, {31'd0, ready_o}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk({nm, " busy ready"}, {31'd0, ready_o}, 32'd0);
        end
        step();
        chk({nm, " done ready"}, {31'd0, ready_o}, 32'd1);
        chk({nm, " result"}, result_o, er);
        chk({nm, " count"}, {29'd0, subst_cnt_o}, {29'd0, ec});
        enable_i = 1'b0;
        step();
        chk({nm, " idle ready"}, {31'd0, ready_o}, 32'd1);
        chk({nm, " result held"}, result_o, er);
    endtask

    initial begin
        vecs[0] = '{STR_OP_UNLEET,    32'h31353348, 32'h6C736548, 3'd3};
        vecs[1] = '{STR_OP_UNLEET_UP, 32'h31353348, 32'h4C534548, 3'd3};
`ifdef STR_UNLEET_EXT_EN
        vecs[2] = '{STR_OP_UNLEET,    32'h37343041, 32'h74616F41, 3'd3};
        vecs[5] = '{STR_OP_UNLEET_UP, 32'h31303932, 32'h4C4F3932, 3'd2};
`else
        vecs[2] = '{STR_OP_UNLEET,    32'h37343041, 32'h37343041, 3'd0};
        vecs[5] = '{STR_OP_UNLEET_UP, 32'h31303932, 32'h4C303932, 3'd1};
`endif
        vecs[3] = '{STR_OP_UNLEET_UP, 32'h33333333, 32'h45454545, 3'd4};
        vecs[4] = '{STR_OP_UNLEET,    32'h00000000, 32'h00000000, 3'd0};
        vecs[6] = '{STR_OP_UNLEET,    32'h65733531, 32'h6573736C, 3'd2};

        rst_n      = 1'b0;
        enable_i   = 1'b0;
        operator_i = STR_OP_LEET;
        operand_i  = 32'd0;
        ex_ready_i = 1'b1;
        step();
        step();
        chk("reset ready", {31'd0, ready_o}, 32'd1);
        chk("reset result", result_o, 32'd0);
        chk("reset count", {29'd0, subst_cnt_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // Foreign operator must not start the unit.
        enable_i   = 1'b1;
        operator_i = STR_OP_LEET;
        operand_i  = 32'h33333333;
        #1;
        chk("foreign op ready", {31'd0, ready_o}, 32'd1);
        for (int k = 0; k < 6; k++) step();
        chk("foreign op ready later", {31'd0, ready_o}, 32'd1);
        chk("foreign op result", result_o, 32'd0);
        enable_i = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].op, vecs[i].opd, vecs[i].res, vecs[i].cnt, $sformatf("vec%0d", i));

        // Stall in DONE with operand changing during the operation.
        enable_i   = 1'b1;
        operator_i = STR_OP_UNLEET;
        operand_i  = 32'h31353348;
        ex_ready_i = 1'b1;
        #1;
        chk("stall accept ready", {31'd0, ready_o}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            operand_i  = 32'h33333333 + k;
            operator_i = STR_OP_UNLEET_UP;
        end
        step();
        ex_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall ready", {31'd0, ready_o}, 32'd1);
            chk("stall result", result_o, 32'h6C736548);
            chk("stall count", {29'd0, subst_cnt_o}, 32'd3);
            step();
        end
        ex_ready_i = 1'b1;
        enable_i   = 1'b0;
        chk("stall release ready", {31'd0, ready_o}, 32'd1);
        chk("stall release result", result_o, 32'h6C736548);
        step();

        // Back in IDLE: a new request drops ready at once. This also starts the abort case.
        enable_i   = 1'b1;
        operator_i = STR_OP_UNLEET;
        operand_i  = 32'h33333333;
        #1;
        chk("post-stall idle accept", {31'd0, ready_o}, 32'd0);
        step();
        step();
        enable_i = 1'b0;
        #1;
        chk("abort busy ready", {31'd0, ready_o}, 32'd0);
        step();
        chk("abort idle ready", {31'd0, ready_o}, 32'd1);
        chk("abort result kept", result_o, 32'h6C736548);
        chk("abort count kept", {29'd0, subst_cnt_o}, 32'd3);
        for (int k = 0; k < 4; k++) step();
        chk("abort result later", result_o, 32'h6C736548);
        chk("abort count later", {29'd0, subst_cnt_o}, 32'd3);

        // Reset while idx = 2.
        enable_i   = 1'b1;
        operator_i = STR_OP_UNLEET;
        operand_i  = 32'h31353348;
        step();
        step();
        step();
        #1;
        rst_n    = 1'b0;
        enable_i = 1'b0;
        #1;
        chk("midreset ready", {31'd0, ready_o}, 32'd1);
        chk("midreset result", result_o, 32'd0);
        chk("midreset count", {29'd0, subst_cnt_o}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        run_op(STR_OP_UNLEET_UP, 32'h31353348, 32'h4C534548, 3'd3, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
